// File: rtl/segre_pkg.sv
// Shared types for the segre core memory path: access sizes, bus widths and
// the arbiter state/latched-request types used by segre_mem_arbiter.
package segre_pkg;

    localparam int WORD_SIZE    = 32;
    localparam int ADDR_SIZE    = 32;
    localparam int ARB_STARVE_W = 4;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } memop_data_type_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        IF_BUSY = 2'b01,
        DM_BUSY = 2'b10
    } arb_state_e;

    typedef struct packed {
        logic [ADDR_SIZE-1:0] addr;
        logic                 we;
        logic [WORD_SIZE-1:0] wdata;
        memop_data_type_e     dtype;
    } arb_req_t;

endpackage

// File: rtl/segre_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data memory with a
// fetch anti-starvation counter. Optional watchdog: define SEGRE_ARB_TIMEOUT_EN.
module segre_mem_arbiter
    import segre_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned STARVE_LIMIT   = 2
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    input  logic                 if_req_i,
    input  logic [ADDR_SIZE-1:0] if_addr_i,
    output logic                 if_gnt_o,
    output logic                 if_rvalid_o,
    output logic [WORD_SIZE-1:0] if_rdata_o,
    input  logic                 dm_req_i,
    input  logic                 dm_we_i,
    input  logic [ADDR_SIZE-1:0] dm_addr_i,
    input  logic [WORD_SIZE-1:0] dm_wdata_i,
    input  memop_data_type_e     dm_type_i,
    output logic                 dm_gnt_o,
    output logic                 dm_rvalid_o,
    output logic [WORD_SIZE-1:0] dm_rdata_o,
    output logic [ADDR_SIZE-1:0] addr_o,
    output logic                 mem_rd_o,
    output logic                 mem_wr_o,
    output logic [WORD_SIZE-1:0] mem_wr_data_o,
    output memop_data_type_e     mem_data_type_o,
    input  logic [WORD_SIZE-1:0] mem_rd_data_i,
    input  logic                 mem_ready_i,
    output logic                 busy_o,
    output logic                 timeout_o
);

    localparam logic [ARB_STARVE_W-1:0] STARVE_MAX = STARVE_LIMIT[ARB_STARVE_W-1:0];

    arb_state_e              state_q, state_d;
    arb_req_t                req_q, req_d;
    logic [ARB_STARVE_W-1:0] starve_q, starve_d;
    logic                    fetch_win;
    logic                    tmo_hit;
    logic                    done;

`ifdef SEGRE_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // The counter holds (busy cycles elapsed - 1), so the hit lands on the
    // TIMEOUT_CYCLES-th busy cycle; a ready in that same cycle still wins.
    always_comb begin
        tmo_hit = 1'b0;
        tmo_d   = '0;
        if (state_q != IDLE) begin
            tmo_hit = !mem_ready_i && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
            if (!mem_ready_i && !tmo_hit) begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign fetch_win = if_req_i && (!dm_req_i || (starve_q == STARVE_MAX));
    assign done      = mem_ready_i || tmo_hit;

    always_comb begin
        state_d         = state_q;
        req_d           = req_q;
        starve_d        = starve_q;
        if_gnt_o        = 1'b0;
        if_rvalid_o     = 1'b0;
        if_rdata_o      = '0;
        dm_gnt_o        = 1'b0;
        dm_rvalid_o     = 1'b0;
        dm_rdata_o      = '0;
        addr_o          = '0;
        mem_rd_o        = 1'b0;
        mem_wr_o        = 1'b0;
        mem_wr_data_o   = '0;
        mem_data_type_o = WORD;
        busy_o          = 1'b0;
        timeout_o       = 1'b0;

        case (state_q)
            IDLE: begin
                // Grants are suppressed under reset so nothing is promised
                // that the reset edge would silently drop.
                if (!rsn_i) begin
                    if (fetch_win) begin
                        if_gnt_o = 1'b1;
                        req_d    = '{addr: if_addr_i, we: 1'b0, wdata: '0, dtype: WORD};
                        starve_d = '0;
                        state_d  = IF_BUSY;
                    end else if (dm_req_i) begin
                        dm_gnt_o = 1'b1;
                        req_d    = '{addr: dm_addr_i, we: dm_we_i, wdata: dm_wdata_i,
                                     dtype: dm_type_i};
                        if (!if_req_i) begin
                            starve_d = '0;
                        end else if (starve_q != STARVE_MAX) begin
                            starve_d = starve_q + 1'b1;
                        end
                        state_d  = DM_BUSY;
                    end
                end
            end
            IF_BUSY: begin
                busy_o   = 1'b1;
                addr_o   = req_q.addr;
                mem_rd_o = 1'b1;
                if (done) begin
                    state_d = IDLE;
                    if (!rsn_i) begin
                        if_rvalid_o = 1'b1;
                        if_rdata_o  = mem_ready_i ? mem_rd_data_i : '0;
                        timeout_o   = tmo_hit;
                    end
                end
            end
            DM_BUSY: begin
                busy_o          = 1'b1;
                addr_o          = req_q.addr;
                mem_rd_o        = !req_q.we;
                mem_wr_o        = req_q.we;
                mem_wr_data_o   = req_q.wdata;
                mem_data_type_o = req_q.dtype;
                if (done) begin
                    state_d = IDLE;
                    if (!rsn_i) begin
                        dm_rvalid_o = 1'b1;
                        dm_rdata_o  = mem_ready_i ? mem_rd_data_i : '0;
                        timeout_o   = tmo_hit;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            state_q  <= IDLE;
            req_q    <= '{addr: '0, we: 1'b0, wdata: '0, dtype: WORD};
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Directed bench for segre_mem_arbiter: per-cycle vector table plus
// starvation, wait-state and (with SEGRE_ARB_TIMEOUT_EN) watchdog sequences.
module tb_segre_mem_arbiter;
    import segre_pkg::*;

`ifdef SEGRE_ARB_TIMEOUT_EN
    localparam int TB_TMO   = 4;
    localparam int WAIT_CYC = 2;
`else
    localparam int TB_TMO   = 64;
    localparam int WAIT_CYC = 5;
`endif

    logic                 clk = 1'b0;
    logic                 rsn;
    logic                 if_req, if_gnt, if_rvalid;
    logic [ADDR_SIZE-1:0] if_addr;
    logic [WORD_SIZE-1:0] if_rdata;
    logic                 dm_req, dm_we, dm_gnt, dm_rvalid;
    logic [ADDR_SIZE-1:0] dm_addr;
    logic [WORD_SIZE-1:0] dm_wdata, dm_rdata;
    memop_data_type_e     dm_type;
    logic [ADDR_SIZE-1:0] addr;
    logic                 mem_rd, mem_wr, mem_ready, busy, timeout;
    logic [WORD_SIZE-1:0] mem_wr_data, mem_rd_data;
    memop_data_type_e     mem_type;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    segre_mem_arbiter #(.TIMEOUT_CYCLES(TB_TMO), .STARVE_LIMIT(2)) dut (
        .clk_i(clk), .rsn_i(rsn),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr),
        .dm_wdata_i(dm_wdata), .dm_type_i(dm_type), .dm_gnt_o(dm_gnt),
        .dm_rvalid_o(dm_rvalid), .dm_rdata_o(dm_rdata),
        .addr_o(addr), .mem_rd_o(mem_rd), .mem_wr_o(mem_wr),
        .mem_wr_data_o(mem_wr_data), .mem_data_type_o(mem_type),
        .mem_rd_data_i(mem_rd_data), .mem_ready_i(mem_ready),
        .busy_o(busy), .timeout_o(timeout)
    );

    typedef struct packed {
        logic        if_gnt;
        logic        if_rvalid;
        logic [31:0] if_rdata;
        logic        dm_gnt;
        logic        dm_rvalid;
        logic [31:0] dm_rdata;
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [31:0] wdata;
        logic [1:0]  dtype;
        logic        busy;
        logic        tmo;
    } out_t;

    typedef struct {
        string            name;
        logic             rst;
        logic             ifr;
        logic [31:0]      ifa;
        logic             dmr;
        logic             we;
        logic [31:0]      dma;
        logic [31:0]      wd;
        memop_data_type_e ty;
        logic             rdy;
        logic [31:0]      rdd;
        out_t             exp;
    } vec_t;

    vec_t vecs[$];

    function automatic out_t exp_o(logic ifg, logic ifv, logic [31:0] ifd,
                                   logic dmg, logic dmv, logic [31:0] dmd,
                                   logic [31:0] a, logic rd, logic wr, logic [31:0] wd,
                                   memop_data_type_e ty, logic bsy);
        out_t o;
        o = '{if_gnt: ifg, if_rvalid: ifv, if_rdata: ifd, dm_gnt: dmg, dm_rvalid: dmv,
              dm_rdata: dmd, addr: a, rd: rd, wr: wr, wdata: wd, dtype: ty, busy: bsy,
              tmo: 1'b0};
        return o;
    endfunction

    function automatic out_t act_o();
        out_t o;
        o = '{if_gnt: if_gnt, if_rvalid: if_rvalid, if_rdata: if_rdata, dm_gnt: dm_gnt,
              dm_rvalid: dm_rvalid, dm_rdata: dm_rdata, addr: addr, rd: mem_rd, wr: mem_wr,
              wdata: mem_wr_data, dtype: mem_type, busy: busy, tmo: timeout};
        return o;
    endfunction

    task automatic add_vec(string n, logic rst, logic ifr, logic [31:0] ifa, logic dmr,
                           logic we, logic [31:0] dma, logic [31:0] wd, memop_data_type_e ty,
                           logic rdy, logic [31:0] rdd, out_t e);
        vec_t v;
        v = '{name: n, rst: rst, ifr: ifr, ifa: ifa, dmr: dmr, we: we, dma: dma, wd: wd,
              ty: ty, rdy: rdy, rdd: rdd, exp: e};
        vecs.push_back(v);
    endtask

    task automatic drive(logic rst, logic ifr, logic [31:0] ifa, logic dmr, logic we,
                         logic [31:0] dma, logic [31:0] wd, memop_data_type_e ty,
                         logic rdy, logic [31:0] rdd);
        rsn = rst; if_req = ifr; if_addr = ifa; dm_req = dmr; dm_we = we;
        dm_addr = dma; dm_wdata = wd; dm_type = ty; mem_ready = rdy; mem_rd_data = rdd;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 3 later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string n, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end else begin
            $display("ok   %s: %0h", n, act);
        end
    endtask

    out_t idle_e;

    initial begin
        idle_e = exp_o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, WORD, 0);

        // name       rst ifr ifa     dmr we dma      wd            ty    rdy rdd
        add_vec("reset",     1, 0, 0,     0, 0, 0,     0,           WORD, 0, 0, idle_e);
        add_vec("f_gnt",     0, 1, 'h100, 0, 0, 0,     0,           WORD, 0, 0,
                exp_o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, WORD, 0));
        add_vec("f_done",    0, 0, 0,     0, 0, 0,     0,           WORD, 1, 'h00500093,
                exp_o(0, 1, 'h00500093, 0, 0, 0, 'h100, 1, 0, 0, WORD, 1));
        add_vec("idle_rdy",  0, 0, 0,     0, 0, 0,     0,           WORD, 1, 'h1234, idle_e);
        add_vec("sim_gnt",   0, 1, 'h200, 1, 1, 'h2000, 'hDEADBEEF, BYTE, 0, 0,
                exp_o(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, WORD, 0));
        add_vec("st_done",   0, 1, 'h200, 0, 0, 'h3000, 0,          WORD, 1, 'h77,
                exp_o(0, 0, 0, 0, 1, 'h77, 'h2000, 0, 1, 'hDEADBEEF, BYTE, 1));
        add_vec("f2_gnt",    0, 1, 'h200, 0, 0, 0,     0,           WORD, 0, 0,
                exp_o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, WORD, 0));
        add_vec("f2_done",   0, 0, 0,     0, 0, 0,     0,           WORD, 1, 'hAAAA5555,
                exp_o(0, 1, 'hAAAA5555, 0, 0, 0, 'h200, 1, 0, 0, WORD, 1));
        add_vec("ld_gnt",    0, 0, 0,     1, 0, 'h44,  0,           HALF, 0, 0,
                exp_o(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, WORD, 0));
        add_vec("ld_wait",   0, 0, 0,     0, 0, 0,     0,           WORD, 0, 0,
                exp_o(0, 0, 0, 0, 0, 0, 'h44, 1, 0, 0, HALF, 1));
        add_vec("ld_done",   0, 0, 0,     0, 0, 0,     0,           WORD, 1, 'hCAFEF00D,
                exp_o(0, 0, 0, 0, 1, 'hCAFEF00D, 'h44, 1, 0, 0, HALF, 1));
        add_vec("rst_gnt",   0, 0, 0,     1, 1, 'h80,  'h11,        WORD, 0, 0,
                exp_o(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, WORD, 0));
        add_vec("rst_b1",    0, 0, 0,     0, 0, 0,     0,           WORD, 0, 0,
                exp_o(0, 0, 0, 0, 0, 0, 'h80, 0, 1, 'h11, WORD, 1));
        add_vec("rst_b2",    1, 0, 0,     0, 0, 0,     0,           WORD, 1, 'h99,
                exp_o(0, 0, 0, 0, 0, 0, 'h80, 0, 1, 'h11, WORD, 1));
        add_vec("rst_after", 0, 0, 0,     0, 0, 0,     0,           WORD, 0, 0, idle_e);
        add_vec("rst_fgnt",  0, 1, 'h300, 0, 0, 0,     0,           WORD, 0, 0,
                exp_o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, WORD, 0));
        add_vec("rst_fdone", 0, 0, 0,     0, 0, 0,     0,           WORD, 1, 'h5,
                exp_o(0, 1, 'h5, 0, 0, 0, 'h300, 1, 0, 0, WORD, 1));

        drive(1, 0, 0, 0, 0, 0, 0, WORD, 0, 0);
        repeat (2) next_cycle();

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].ifr, vecs[i].ifa, vecs[i].dmr, vecs[i].we,
                  vecs[i].dma, vecs[i].wd, vecs[i].ty, vecs[i].rdy, vecs[i].rdd);
            #3;
            check(vecs[i].name, 256'(act_o()), 256'(vecs[i].exp));
            next_cycle();
        end

        // Starvation: both requesters held high, memory always ready.
        begin
            logic [1:0] order [6];
            order[0] = 2'b01; order[1] = 2'b01; order[2] = 2'b10;
            order[3] = 2'b01; order[4] = 2'b01; order[5] = 2'b10;
            for (int k = 0; k < 6; k++) begin
                drive(0, 1, 'h400, 1, 0, 'h600, 0, WORD, 1, 'h1000 + k);
                #3;
                check($sformatf("starve_gnt%0d {if,dm}", k), 256'({if_gnt, dm_gnt}),
                      256'(order[k]));
                next_cycle();
                #3;
                check($sformatf("starve_done%0d {if_rv,dm_rv}", k),
                      256'({if_rvalid, dm_rvalid}), 256'(order[k]));
                next_cycle();
            end
        end

        // Wait states: load held for WAIT_CYC cycles before ready.
        begin
            int rv_cnt = 0;
            drive(0, 0, 0, 1, 0, 'h500, 0, WORD, 0, 0);
            #3;
            check("wait_gnt", 256'(dm_gnt), 256'(1));
            next_cycle();
            for (int c = 0; c <= WAIT_CYC; c++) begin
                drive(0, 0, 0, 0, 0, 0, 0, WORD, (c == WAIT_CYC), 'hBEEF);
                #3;
                check($sformatf("wait_c%0d {addr,rd,wr,busy,tmo}", c),
                      256'({addr, mem_rd, mem_wr, busy, timeout}),
                      256'({32'h500, 1'b1, 1'b0, 1'b1, 1'b0}));
                if (dm_rvalid) rv_cnt++;
                next_cycle();
            end
            for (int c = 0; c < 2; c++) begin
                drive(0, 0, 0, 0, 0, 0, 0, WORD, 0, 0);
                #3;
                if (dm_rvalid) rv_cnt++;
                next_cycle();
            end
            check("wait_rvalid_count", 256'(rv_cnt), 256'(1));
            #3;
            check("wait_busy_after", 256'(busy), 256'(0));
        end

`ifdef SEGRE_ARB_TIMEOUT_EN
        // Watchdog: memory never answers.
        next_cycle();
        drive(0, 0, 0, 1, 0, 'h700, 0, WORD, 0, 'hFFFF);
        #3;
        check("tmo_gnt", 256'(dm_gnt), 256'(1));
        next_cycle();
        for (int c = 1; c <= TB_TMO; c++) begin
            drive(0, 0, 0, 0, 0, 0, 0, WORD, 0, 'hFFFF);
            #3;
            check($sformatf("tmo_c%0d {tmo,dm_rv,dm_rdata}", c),
                  256'({timeout, dm_rvalid, dm_rdata}),
                  256'({(c == TB_TMO), (c == TB_TMO), 32'h0}));
            next_cycle();
        end
        #3;
        check("tmo_idle {busy,rd}", 256'({busy, mem_rd}), 256'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
